trickbox_arbiter: RTL and testbench

Sequential arbiter sharing one trickbox debug port (cycle-time read, character output) among NUM_REQ bus requesters, for example the instruction and data memory stages or several cores. It serialises accesses and gives each a registered response with unmapped-address error flagging. A requester that starts a PUTC string keeps the trickbox until it writes the terminating NUL, so console lines from different requesters never interleave.

---
 rtl/trickbox_arbiter_if.sv | 34 +++
 rtl/trickbox_arbiter.sv | 175 +++++++++++++++++
 tb/tb_trickbox_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trickbox_arbiter_if.sv
// Bundle between the bus requesters, the arbiter and the trickbox debug port.
// Latency: none, wires only.
// Backpressure: carried by the request level / one-hot ack handshake inside.
interface trickbox_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_read;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*32-1:0]         req_wdata;
    logic [31:0]                   req_rdata;
    logic [NUM_REQ-1:0]            req_ack;
    logic                          req_err;
    logic [ADDR_WIDTH-1:0]         tb_addr;
    logic                          tb_read;
    logic                          tb_write;
    logic [31:0]                   tb_wdata;
    logic [31:0]                   tb_rdata;
    logic                          tb_taken;
    logic                          lock_timeout;

    // Arbiter side: consumes requests and trickbox responses.
    modport slave (
        input  req_addr, req_read, req_write, req_wdata, tb_rdata, tb_taken,
        output req_rdata, req_ack, req_err, tb_addr, tb_read, tb_write, tb_wdata, lock_timeout
    );

    // Environment side: requesters plus the trickbox itself.
    modport master (
        output req_addr, req_read, req_write, req_wdata, tb_rdata, tb_taken,
        input  req_rdata, req_ack, req_err, tb_addr, tb_read, tb_write, tb_wdata, lock_timeout
    );
endinterface

// File: rtl/trickbox_arbiter.sv
// Shares one trickbox debug port among NUM_REQ requesters; PUTC strings lock the port to one requester.
// Latency: request seen in IDLE -> trickbox strobe next cycle -> registered ack the cycle after.
// Backpressure: requests are level-held until their one-hot ack; losers and locked-out requesters wait.
module trickbox_arbiter #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    NUM_REQ      = 2,
    parameter logic [ADDR_WIDTH-1:0] PUTC_PORT    = 32'hAAAA0008,
    parameter int                    LOCK_TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset_n,
    trickbox_arbiter_if.slave  bus
);
    localparam int               IDX_W     = $clog2(NUM_REQ);
    localparam int               CNT_W     = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   CNT_LIMIT = (CNT_W + 1)'(LOCK_TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RESP} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [IDX_W-1:0]       r_rr_ptr;
    logic [IDX_W-1:0]       r_winner;
    logic [IDX_W-1:0]       r_lock_owner;
    logic                   r_lock_vld;
    logic [CNT_W-1:0]       r_idle_cnt;
    logic                   r_lock_timeout;

    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [31:0]            r_wdata;
    logic                   r_rd;

    logic [NUM_REQ-1:0]     r_ack;
    logic [31:0]            r_rdata;
    logic                   r_err;

    logic [NUM_REQ-1:0]     w_req;
    logic [NUM_REQ-1:0]     w_elig;
    logic                   w_found;
    logic [IDX_W-1:0]       w_winner;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [31:0]            w_sel_wdata;
    logic                   w_sel_rd;
    logic                   w_owner_req;
    logic                   w_grant;
    logic                   w_putc_hit;

    assign w_req       = bus.req_read | bus.req_write;
    assign w_owner_req = w_req[r_lock_owner];
    assign w_grant     = (r_state == ST_IDLE) && w_found;
    // Only taken writes to the character port move the lock; untaken ones are ignored.
    assign w_putc_hit  = (r_state == ST_GRANT) && !r_rd && (r_addr == PUTC_PORT) && bus.tb_taken;

    // While a string is open only its owner may compete.
    always_comb begin
        w_elig = w_req;
        if (r_lock_vld) begin
            w_elig               = '0;
            w_elig[r_lock_owner] = w_req[r_lock_owner];
        end
    end

    // Round-robin search starting at r_rr_ptr; read wins over write when both are set.
    always_comb begin
        int idx;
        idx         = 0;
        w_found     = 1'b0;
        w_winner    = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_rd    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && w_elig[idx]) begin
                w_found     = 1'b1;
                w_winner    = IDX_W'(idx);
                w_sel_addr  = bus.req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = bus.req_wdata[idx*32 +: 32];
                w_sel_rd    = bus.req_read[idx];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next state: a fixed IDLE -> GRANT -> RESP loop once something is eligible.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_found) w_state_nxt = ST_GRANT;
            ST_GRANT: w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the winner's access and advance the round-robin pointer past it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rd     <= 1'b0;
            r_winner <= '0;
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_rd     <= w_sel_rd;
            r_winner <= w_winner;
            r_rr_ptr <= (w_winner == LAST_IDX) ? '0 : w_winner + 1'b1;
        end
    end

    // Capture the trickbox reply at the end of GRANT; the response lives for the RESP cycle only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ack   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (r_state == ST_GRANT) begin
            r_ack   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_winner;
            r_rdata <= r_rd ? bus.tb_rdata : 32'h0;
            r_err   <= ~bus.tb_taken;
        end else begin
            r_ack   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end
    end

    // String lock plus the idle watchdog that frees a lock whose owner went silent.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_vld     <= 1'b0;
            r_lock_owner   <= '0;
            r_idle_cnt     <= '0;
            r_lock_timeout <= 1'b0;
        end else if (w_putc_hit) begin
            r_idle_cnt <= '0;
            if (r_wdata[7:0] != 8'h00) begin
                r_lock_vld   <= 1'b1;
                r_lock_owner <= r_winner;
            end else begin
                r_lock_vld   <= 1'b0;
            end
        end else if ((r_state == ST_IDLE) && r_lock_vld) begin
            if (w_owner_req) begin
                // Owner is the only eligible requester, so this is its grant.
                r_idle_cnt <= '0;
            end else if (({1'b0, r_idle_cnt} + 1'b1) >= CNT_LIMIT) begin
                r_lock_vld     <= 1'b0;
                r_idle_cnt     <= '0;
                r_lock_timeout <= 1'b1;
            end else if (r_idle_cnt != CNT_MAX) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    assign bus.req_ack      = r_ack;
    assign bus.req_rdata    = r_rdata;
    assign bus.req_err      = r_err;
    assign bus.tb_addr      = r_addr;
    assign bus.tb_wdata     = r_wdata;
    assign bus.tb_read      = (r_state == ST_GRANT) &&  r_rd;
    assign bus.tb_write     = (r_state == ST_GRANT) && !r_rd;
    assign bus.lock_timeout = r_lock_timeout;
endmodule

// File: tb/tb_trickbox_arbiter.sv
// Bench for trickbox_arbiter: per-requester access queues, a transaction-level arbitration model and a scoreboard.
// Latency: expected ack cycle is recorded per access and checked by the monitor.
// Backpressure: requests stay on the pins until the model retires them after their ack.
module tb_trickbox_arbiter;
    localparam int          AW   = 32;
    localparam int          NR   = 2;
    localparam int          LT   = 4;
    localparam logic [31:0] PUTC = 32'hAAAA0008;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        both;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        int          who;
        logic [31:0] addr;
        logic        rd;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          ack_cyc;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    trickbox_arbiter_if #(.ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

    trickbox_arbiter #(
        .ADDR_WIDTH(AW), .NUM_REQ(NR), .PUTC_PORT(PUTC), .LOCK_TIMEOUT(LT)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Trickbox model: claims the 0xAAAA_xxxx window, reads return a value derived from the address.
    function automatic logic tbx_taken(input logic [31:0] a);
        return a[31:16] == 16'hAAAA;
    endfunction
    function automatic logic [31:0] tbx_rdata(input logic [31:0] a);
        return tbx_taken(a) ? (32'h1234 + {16'h0, a[15:0]}) : (32'hDEAD0000 | {16'h0, a[15:0]});
    endfunction

    always_comb begin
        bus.tb_taken = tbx_taken(bus.tb_addr);
        bus.tb_rdata = tbx_rdata(bus.tb_addr);
    end

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    acc_t rq [NR][$];
    exp_t sbq[$];

    // Model state: phase of the shared port, fairness pointer, string lock.
    int   ms         = 0;
    int   gw         = 0;
    int   rr         = 0;
    int   lock_owner = -1;
    int   idle_cnt   = 0;
    logic exp_lto    = 1'b0;
    logic rnd_on     = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic acc_t mk(input logic [31:0] a, input logic rd, input logic both, input logic [31:0] d);
        acc_t x;
        x.addr = a; x.rd = rd; x.both = both; x.wdata = d;
        return x;
    endfunction

    task automatic drive_pins();
        logic [NR*AW-1:0] a;
        logic [NR-1:0]    r;
        logic [NR-1:0]    w;
        logic [NR*32-1:0] d;
        a = '0; r = '0; w = '0; d = '0;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                a[i*AW +: AW] = rq[i][0].addr;
                d[i*32 +: 32] = rq[i][0].wdata;
                r[i]          = rq[i][0].rd;
                w[i]          = !rq[i][0].rd || rq[i][0].both;
            end
        end
        bus.req_addr  = a;
        bus.req_read  = r;
        bus.req_write = w;
        bus.req_wdata = d;
    endtask

    task automatic gen_random();
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                logic [31:0] a;
                logic        rd;
                logic [31:0] d;
                int          sel;
                sel = $urandom_range(0, 3);
                d   = $urandom;
                rd  = ($urandom_range(0, 1) == 1);
                case (sel)
                    0: begin a = PUTC; rd = 1'b0; if ($urandom_range(0, 2) == 0) d[7:0] = 8'h00; end
                    1: a = 32'hAAAA0000 + 32'($urandom_range(0, 63));
                    2: a = 32'($urandom_range(0, 63));
                    default: begin a = PUTC; rd = 1'b1; end
                endcase
                rq[i].push_back(mk(a, rd, rd && ($urandom_range(0, 1) == 1), d));
            end
        end
    endtask

    // Arbitration decision for one free cycle of the port, straight from the sharing rules.
    task automatic model_idle();
        int win;
        win = -1;
        if (lock_owner >= 0) begin
            if (rq[lock_owner].size() > 0) begin
                win      = lock_owner;
                idle_cnt = 0;
            end else begin
                idle_cnt++;
                if (idle_cnt >= LT) begin
                    lock_owner = -1;
                    idle_cnt   = 0;
                    exp_lto    = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (rr + k) % NR;
                if (win < 0 && rq[i].size() > 0) win = i;
            end
        end
        if (win >= 0) begin
            acc_t a;
            exp_t e;
            a = rq[win][0];
            e.who     = win;
            e.addr    = a.addr;
            e.rd      = a.rd;
            e.wdata   = a.wdata;
            e.rdata   = a.rd ? tbx_rdata(a.addr) : 32'h0;
            e.err     = !tbx_taken(a.addr);
            e.ack_cyc = cyc + 2;
            sbq.push_back(e);
            rr = (win + 1) % NR;
            if (!a.rd && a.addr == PUTC && tbx_taken(a.addr)) begin
                if (a.wdata[7:0] != 8'h00) begin
                    lock_owner = win;
                    idle_cnt   = 0;
                end else begin
                    lock_owner = -1;
                end
            end
            gw = win;
            ms = 1;
        end
    endtask

    task automatic step();
        int cur;
        @(negedge clock);
        cur = ms;
        if (cur == 2) void'(rq[gw].pop_front());
        if (rnd_on) gen_random();
        drive_pins();
        case (cur)
            0:       model_idle();
            1:       ms = 2;
            default: ms = 0;
        endcase
    endtask

    task automatic run_until_quiet(input string nm);
        int n;
        n = 0;
        while (!(rq[0].size() == 0 && rq[1].size() == 0 && ms == 0 && sbq.size() == 0) && n < 300) begin
            step();
            n++;
        end
        chk({nm, "_drained"}, (n < 300) ? 1 : 0, 1);
    endtask

    // Monitor: strobes and acks are matched against the head of the scoreboard.
    initial begin
        exp_t          e;
        logic [NR-1:0] oh;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (bus.tb_read || bus.tb_write) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_strobe", {62'h0, bus.tb_read, bus.tb_write}, 0);
                    end else begin
                        chk("strobe_cycle", cyc, sbq[0].ack_cyc - 1);
                        chk("tb_addr", bus.tb_addr, sbq[0].addr);
                        chk("tb_read", bus.tb_read, sbq[0].rd);
                        chk("tb_write", bus.tb_write, !sbq[0].rd);
                        if (!sbq[0].rd) chk("tb_wdata", bus.tb_wdata, sbq[0].wdata);
                    end
                end
                if (bus.req_ack != '0) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_ack", bus.req_ack, 0);
                    end else begin
                        e  = sbq.pop_front();
                        oh = '0;
                        oh[e.who] = 1'b1;
                        chk("ack_onehot", bus.req_ack, oh);
                        chk("ack_cycle", cyc, e.ack_cyc);
                        chk("rdata", bus.req_rdata, e.rdata);
                        chk("err", bus.req_err, e.err);
                    end
                end else begin
                    chk("idle_rdata", bus.req_rdata, 0);
                    chk("idle_err", bus.req_err, 0);
                end
            end
        end
    end

    initial begin
        drive_pins();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_ack", bus.req_ack, 0);
        chk("rst_rdata", bus.req_rdata, 0);
        chk("rst_err", bus.req_err, 0);
        chk("rst_tb_read", bus.tb_read, 0);
        chk("rst_tb_write", bus.tb_write, 0);
        chk("rst_tb_addr", bus.tb_addr, 0);
        chk("rst_tb_wdata", bus.tb_wdata, 0);
        chk("rst_lock_timeout", bus.lock_timeout, 0);
        reset_n = 1'b1;

        // Single mapped read from requester 0.
        rq[0].push_back(mk(32'hAAAA0000, 1'b1, 1'b0, 32'h0));
        run_until_quiet("single_read");

        // Unmapped write from requester 1.
        rq[1].push_back(mk(32'h00000000, 1'b0, 1'b0, 32'h00000055));
        run_until_quiet("unmapped");

        // Both requesters hammering reads: strict alternation.
        for (int j = 0; j < 2; j++) begin
            rq[0].push_back(mk(32'hAAAA0100 + 32'(j), 1'b1, 1'b0, 32'h0));
            rq[1].push_back(mk(32'hAAAA0200 + 32'(j), 1'b1, 1'b0, 32'h0));
        end
        run_until_quiet("round_robin");

        // "Hi" string from requester 0 keeps requester 1 out until the NUL.
        rq[0].push_back(mk(PUTC, 1'b0, 1'b0, 32'h48));
        rq[0].push_back(mk(PUTC, 1'b0, 1'b0, 32'h69));
        rq[0].push_back(mk(PUTC, 1'b0, 1'b0, 32'h00));
        rq[1].push_back(mk(32'hAAAA0300, 1'b1, 1'b0, 32'h0));
        run_until_quiet("string_lock");
        chk("no_timeout_after_string", bus.lock_timeout, 0);

        // Owner opens a string and goes silent; the watchdog frees the port.
        rq[0].push_back(mk(PUTC, 1'b0, 1'b0, 32'h41));
        rq[1].push_back(mk(32'hAAAA0400, 1'b1, 1'b0, 32'h0));
        run_until_quiet("timeout");
        chk("lock_timeout_set", bus.lock_timeout, 1);

        // Random traffic.
        rnd_on = 1'b1;
        repeat (900) step();
        rnd_on = 1'b0;
        run_until_quiet("random");
        chk("lock_timeout_sticky", bus.lock_timeout, exp_lto);

        // Reset while a write strobe is on the trickbox port.
        rq[0].push_back(mk(32'hAAAA0010, 1'b0, 1'b0, 32'hCAFE0001));
        step();
        @(negedge clock);
        #1;
        chk("pre_reset_tb_write", bus.tb_write, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_tb_write", bus.tb_write, 0);
        chk("mid_reset_ack", bus.req_ack, 0);
        chk("mid_reset_tb_addr", bus.tb_addr, 0);
        chk("mid_reset_tb_wdata", bus.tb_wdata, 0);
        chk("mid_reset_lock_timeout", bus.lock_timeout, 0);
        sbq.delete();
        for (int i = 0; i < NR; i++) rq[i].delete();
        ms = 0; rr = 0; lock_owner = -1; idle_cnt = 0; exp_lto = 1'b0;
        drive_pins();
        repeat (2) begin
            @(negedge clock);
            chk("in_reset_ack", bus.req_ack, 0);
        end
        #1 reset_n = 1'b1;
        rq[0].push_back(mk(32'hAAAA0020, 1'b1, 1'b0, 32'h0));
        rq[1].push_back(mk(32'hAAAA0030, 1'b1, 1'b0, 32'h0));
        run_until_quiet("post_reset_tie");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
